dot_product_accumulator: RTL



---
 rtl/dot_product_accumulator_pkg.sv | 17 +
 rtl/dot_product_accumulator_if.sv | 31 +++
 rtl/dot_product_accumulator_sat_clamp.sv | 29 ++
 rtl/dot_product_accumulator.sv | 110 +++++++++++
 4 files changed

// File: rtl/dot_product_accumulator_pkg.sv
// Shared types and constants for the dot-product MAC back end and its
// reusable saturator.
package dpa_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [31:0] SAT_MAX = 32'h7FFF_FFFF;
  localparam logic [31:0] SAT_MIN = 32'h8000_0000;

  localparam int DEFAULT_ACC_WIDTH = 40;
  localparam int DEFAULT_LEN_WIDTH = 8;

endpackage

// File: rtl/dot_product_accumulator_if.sv
// Job request, term stream and result handshake of the dot-product accumulator.
// master = the driving environment, slave = the accumulator.
interface dot_product_accumulator_if
  import dpa_pkg::*;
#(
  parameter int LEN_WIDTH = DEFAULT_LEN_WIDTH
) ();

  logic                 start;
  logic [LEN_WIDTH-1:0] length;
  logic                 mul_enable;
  logic                 in_valid;
  logic                 in_ready;
  logic [31:0]          product;
  logic                 out_valid;
  logic                 out_ready;
  logic [31:0]          out_result;
  logic                 out_overflow;
  logic                 busy;

  modport master (
    output start, length, in_valid, product, out_ready,
    input  mul_enable, in_ready, out_valid, out_result, out_overflow, busy
  );

  modport slave (
    input  start, length, in_valid, product, out_ready,
    output mul_enable, in_ready, out_valid, out_result, out_overflow, busy
  );

endinterface

// File: rtl/dot_product_accumulator_sat_clamp.sv
// Combinational clamp of a wide signed accumulator to a signed 32-bit result,
// flagging when the value had to be limited.
module sat_clamp
  import dpa_pkg::*;
#(
  parameter int ACC_WIDTH = DEFAULT_ACC_WIDTH
) (
  input  logic [ACC_WIDTH-1:0] acc,
  output logic [31:0]          result,
  output logic                 overflow
);

  // The value fits in 32 bits when bit 31 and everything above it agree.
  logic [ACC_WIDTH-32:0] upper;
  logic                  fits;

  assign upper = acc[ACC_WIDTH-1:31];
  assign fits  = (&upper) | ~(|upper);

  always_comb begin
    result   = acc[31:0];
    overflow = 1'b0;
    if (!fits) begin
      overflow = 1'b1;
      result   = acc[ACC_WIDTH-1] ? SAT_MIN : SAT_MAX;
    end
  end

endmodule

// File: rtl/dot_product_accumulator.sv
// Sums a programmed number of signed 32-bit products into a wide accumulator
// and returns the saturated total over a valid/ready handshake.
module dot_product_accumulator
  import dpa_pkg::*;
#(
  parameter int ACC_WIDTH = DEFAULT_ACC_WIDTH,
  parameter int LEN_WIDTH = DEFAULT_LEN_WIDTH
) (
  input logic                     clk,
  input logic                     rst_n,
  dot_product_accumulator_if.slave bus
);

  state_t                 state_reg, state_next;
  logic [ACC_WIDTH-1:0]   acc_reg, acc_next;
  logic [LEN_WIDTH-1:0]   remaining_reg, remaining_next;
  logic [31:0]            result_reg, result_next;
  logic                   overflow_reg, overflow_next;

  logic                   accum_active;
  logic                   beat;
  logic [ACC_WIDTH-1:0]   acc_sum;
  logic [31:0]            clamp_result;
  logic                   clamp_overflow;

  assign accum_active = (state_reg == ACCUM);
  assign beat         = accum_active && bus.in_valid;
  assign acc_sum      = acc_reg + {{(ACC_WIDTH-32){bus.product[31]}}, bus.product};

  // Clamp the post-add value so the final beat's result is registered on the
  // same edge that accepts it.
  sat_clamp #(
    .ACC_WIDTH(ACC_WIDTH)
  ) u_sat_clamp (
    .acc     (acc_sum),
    .result  (clamp_result),
    .overflow(clamp_overflow)
  );

  always_comb begin
    state_next     = state_reg;
    acc_next       = acc_reg;
    remaining_next = remaining_reg;
    result_next    = result_reg;
    overflow_next  = overflow_reg;

    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          acc_next = '0;
          if (bus.length != '0) begin
            remaining_next = bus.length;
            state_next     = ACCUM;
          end else begin
            result_next   = '0;
            overflow_next = 1'b0;
            state_next    = DONE;
          end
        end
      end

      ACCUM: begin
        if (beat) begin
          acc_next       = acc_sum;
          remaining_next = remaining_reg - 1'b1;
          if (remaining_reg == {{(LEN_WIDTH-1){1'b0}}, 1'b1}) begin
            result_next   = clamp_result;
            overflow_next = clamp_overflow;
            state_next    = DONE;
          end
        end
      end

      DONE: begin
        if (bus.out_ready) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      acc_reg       <= '0;
      remaining_reg <= '0;
      result_reg    <= '0;
      overflow_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      acc_reg       <= acc_next;
      remaining_reg <= remaining_next;
      result_reg    <= result_next;
      overflow_reg  <= overflow_next;
    end
  end

  // Handshake and status outputs are pure state decodes.
  assign bus.in_ready     = accum_active;
  assign bus.mul_enable   = accum_active;
  assign bus.out_valid    = (state_reg == DONE);
  assign bus.busy         = (state_reg != IDLE);
  assign bus.out_result   = result_reg;
  assign bus.out_overflow = overflow_reg;

endmodule
